// File: rtl/parity_frame_engine.sv
// parity_frame_engine: folds a valid/ready stream of DATA_W-bit words into one
// parity bit per frame (frames end on in_last). Generate mode reports the
// parity; check mode also flags a mismatch against in_expect.
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         word handshake; in_ready is low while a result is held
//   in_data, in_last          word payload and end-of-frame marker
//   in_odd, in_check          parity sense and mode, sampled on a frame's first word
//   in_expect                 expected parity, sampled with the last word
//   out_valid/out_ready       result handshake
//   out_parity, out_err       frame parity and check-mode mismatch
//   out_count, out_ovf        saturating word count and saturation flag
module parity_frame_engine #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CNT_W       = 8,
  parameter bit          ODD_DEFAULT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_odd,
  input  logic              in_check,
  input  logic              in_expect,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_parity,
  output logic              out_err,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic               acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               odd_q, odd_d;
  logic               chk_q, chk_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_parity_q, out_parity_d;
  logic               out_err_q, out_err_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  // Values the frame state would take if the current word is accepted.
  logic               accept;
  logic               first;
  logic               word_par;
  logic               sat;
  logic               odd_nx;
  logic               chk_nx;
  logic               acc_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               ovf_nx;
  logic               par_nx;

  // Candidate accumulator/counter update; first word takes sense and mode directly
  // so a single-word frame sees them on the same edge.
  always_comb begin
    accept   = in_valid & in_ready_q;
    first    = (state_q == IDLE);
    word_par = ^in_data;
    sat      = !first && (cnt_q == CNT_MAX);
    odd_nx   = first ? in_odd   : odd_q;
    chk_nx   = first ? in_check : chk_q;
    acc_nx   = first ? word_par : (acc_q ^ word_par);
    cnt_nx   = first ? CNT_W'(1) : (sat ? cnt_q : cnt_q + CNT_W'(1));
    ovf_nx   = first ? 1'b0 : (ovf_q | sat);
    par_nx   = acc_nx ^ odd_nx;
  end

  // Next-state and result logic.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    odd_d        = odd_q;
    chk_d        = chk_q;
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    out_err_d    = out_err_q;
    out_count_d  = out_count_q;
    out_ovf_d    = out_ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_nx;
          cnt_d = cnt_nx;
          ovf_d = ovf_nx;
          odd_d = odd_nx;
          chk_d = chk_nx;
          if (in_last) begin
            state_d      = HOLD;
            out_valid_d  = 1'b1;
            out_parity_d = par_nx;
            out_err_d    = chk_nx & (par_nx != in_expect);
            out_count_d  = cnt_nx;
            out_ovf_d    = ovf_nx;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_d       = 1'b0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      odd_q        <= ODD_DEFAULT;
      chk_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_err_q    <= 1'b0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      odd_q        <= odd_d;
      chk_q        <= chk_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_err_q    <= out_err_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_err    = out_err_q;
  assign out_count  = out_count_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_parity_frame_engine.sv
// Directed bench for parity_frame_engine: a 3-bit instance for the single-word
// truth table and an 8-bit instance with a 2-bit counter for everything else.
module tb_parity_frame_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 3-bit instance
  logic       a_in_valid, a_in_ready, a_in_last, a_in_odd, a_in_check, a_in_expect;
  logic [2:0] a_in_data;
  logic       a_out_valid, a_out_ready, a_out_parity, a_out_err, a_out_ovf;
  logic [7:0] a_out_count;

  // 8-bit instance, 2-bit counter
  logic       b_in_valid, b_in_ready, b_in_last, b_in_odd, b_in_check, b_in_expect;
  logic [7:0] b_in_data;
  logic       b_out_valid, b_out_ready, b_out_parity, b_out_err, b_out_ovf;
  logic [1:0] b_out_count;

  parity_frame_engine #(.DATA_W(3), .CNT_W(8), .ODD_DEFAULT(1'b0)) u_w3 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_last(a_in_last), .in_odd(a_in_odd), .in_check(a_in_check),
    .in_expect(a_in_expect), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_parity(a_out_parity), .out_err(a_out_err), .out_count(a_out_count),
    .out_ovf(a_out_ovf)
  );

  parity_frame_engine #(.DATA_W(8), .CNT_W(2), .ODD_DEFAULT(1'b0)) u_w8 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .in_odd(b_in_odd), .in_check(b_in_check),
    .in_expect(b_in_expect), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_parity(b_out_parity), .out_err(b_out_err), .out_count(b_out_count),
    .out_ovf(b_out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word to the 8-bit instance and hold it until accepted (bounded).
  task automatic b_send(input logic [7:0] d, input logic last, input logic odd,
                        input logic chk, input logic exp_bit);
    int waited = 0;
    b_in_data   = d;
    b_in_last   = last;
    b_in_odd    = odd;
    b_in_check  = chk;
    b_in_expect = exp_bit;
    b_in_valid  = 1'b1;
    while (!b_in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("b_ready_wait", 32'(b_in_ready), 32'd1);
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic b_release();
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check("b_release_valid", 32'(b_out_valid), 32'd0);
    check("b_release_ready", 32'(b_in_ready), 32'd1);
  endtask

  task automatic b_result(input string tag, input logic par, input logic err,
                          input logic [1:0] cnt, input logic ovf);
    check({tag, "_valid"},  32'(b_out_valid),  32'd1);
    check({tag, "_parity"}, 32'(par_get()),    32'(par));
    check({tag, "_err"},    32'(b_out_err),    32'(err));
    check({tag, "_count"},  32'(b_out_count),  32'(cnt));
    check({tag, "_ovf"},    32'(b_out_ovf),    32'(ovf));
  endtask

  function automatic logic par_get();
    return b_out_parity;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tab;
    exp_tab = 8'b1001_0110;

    a_in_valid = 0; a_in_last = 0; a_in_odd = 0; a_in_check = 0; a_in_expect = 0;
    a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 0; b_in_last = 0; b_in_odd = 0; b_in_check = 0; b_in_expect = 0;
    b_in_data = '0; b_out_ready = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_b_valid",  32'(b_out_valid),  32'd0);
    check("rst_b_ready",  32'(b_in_ready),   32'd1);
    check("rst_b_count",  32'(b_out_count),  32'd0);
    check("rst_b_parity", 32'(b_out_parity), 32'd0);
    check("rst_a_valid",  32'(a_out_valid),  32'd0);

    // 3-bit truth table, single-word frames, consumer always ready
    for (int v = 0; v < 8; v++) begin
      int waited = 0;
      a_in_data  = 3'(v);
      a_in_last  = 1'b1;
      a_in_valid = 1'b1;
      while (!a_in_ready && waited < 20) begin
        tick();
        waited++;
      end
      check("a_ready_wait", 32'(a_in_ready), 32'd1);
      tick();
      a_in_valid = 1'b0;
      check($sformatf("a_valid_%0d", v),  32'(a_out_valid),  32'd1);
      check($sformatf("a_parity_%0d", v), 32'(a_out_parity), 32'(exp_tab[v]));
      check($sformatf("a_count_%0d", v),  32'(a_out_count),  32'd1);
      check($sformatf("a_err_%0d", v),    32'(a_out_err),    32'd0);
      check($sformatf("a_ovf_%0d", v),    32'(a_out_ovf),    32'd0);
    end

    // Odd sense, three words: popcounts 1+2+8=11 -> 1, inverted -> 0
    b_send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    check("odd_mid_valid", 32'(b_out_valid), 32'd0);
    b_send(8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    b_send(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    b_result("odd3", 1'b1 ^ 1'b1, 1'b0, 2'd3, 1'b0);
    b_release();

    // Check mode: A5 has even popcount -> parity 0
    b_send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    b_result("chk_mis", 1'b0, 1'b1, 2'd1, 1'b0);
    b_release();
    b_send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    b_result("chk_ok", 1'b0, 1'b0, 2'd1, 1'b0);

    // Backpressure: result held, source keeps offering 8'hFF
    b_in_data  = 8'hFF;
    b_in_last  = 1'b1;
    b_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_ready",  32'(b_in_ready),   32'd0);
      check("bp_valid",  32'(b_out_valid),  32'd1);
      check("bp_parity", 32'(b_out_parity), 32'd0);
      check("bp_count",  32'(b_out_count),  32'd1);
    end
    b_out_ready = 1'b1;
    tick();
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    check("bp_rel_valid", 32'(b_out_valid), 32'd0);
    check("bp_rel_ready", 32'(b_in_ready),  32'd1);

    // Idle gap mid-frame: 01, pause, 01(last) -> even parity 0, count 2
    b_send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("gap_valid", 32'(b_out_valid), 32'd0);
    b_send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    b_result("gap", 1'b0, 1'b0, 2'd2, 1'b0);
    b_release();

    // Reset mid-frame discards the partial frame
    b_send(8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
    b_send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 32'(b_out_valid), 32'd0);
    check("mrst_ready", 32'(b_in_ready),  32'd1);
    check("mrst_count", 32'(b_out_count), 32'd0);
    b_send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    b_result("mrst_frame", 1'b1, 1'b0, 2'd1, 1'b0);
    b_release();

    // Counter saturation with CNT_W=2: five zero words -> count 3, ovf 1
    for (int w = 0; w < 5; w++) b_send(8'h00, 1'(w == 4), 1'b0, 1'b0, 1'b0);
    b_result("sat", 1'b0, 1'b0, 2'd3, 1'b1);
    b_release();
    b_send(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    b_result("after_sat", 1'b0, 1'b0, 2'd1, 1'b0);
    b_release();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_engine.md
Name: parity_frame_engine

Overview:
- Parametrised, clocked successor to the team's 3-input XOR gate.
- Reduces a stream of DATA_W-bit words to one parity bit per frame.
- Two modes: generate, or check against a supplied expected bit.
- Sits between a valid/ready word source and a result consumer; frames are delimited by in_last.

Parameters:
- DATA_W, 8: width of each input word (≥1).
- CNT_W, 8: width of the frame word counter.
- ODD_DEFAULT, 0: reset value of the parity sense (0 = even, 1 = odd).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  source word valid
- in_ready  out  1  engine can accept a word
- in_data  in  DATA_W  word to fold into parity
- in_last  in  1  word is the final one of the frame
- in_odd  in  1  parity sense, sampled on the first accepted word of a frame
- in_check  in  1  mode, sampled on the first word: 0 = generate, 1 = check
- in_expect  in  1  expected parity, sampled with the last word (check mode only)
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- out_parity  out  1  computed frame parity
- out_err  out  1  check-mode mismatch
- out_count  out  CNT_W  words accepted in frame, saturating
- out_ovf  out  1  counter saturated during frame

Behaviour:
- Acceptance: a word is accepted when in_valid & in_ready on a rising edge.
- States: IDLE, ACCUM, HOLD. in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- IDLE, word accepted:
  - latch odd_q = in_odd and chk_q = in_check.
  - acc = ^in_data; cnt = 1.
  - if in_last → HOLD, else → ACCUM.
- ACCUM, word accepted:
  - acc ^= ^in_data; cnt = cnt + 1, saturating at 2^CNT_W−1.
  - a saturating increment sets ovf_q.
  - in_odd/in_check ignored after the first word; if in_last → HOLD.
- Entering HOLD, registered on the same edge that accepts the last word:
  - out_parity = acc_final ^ odd_q.
  - out_err = chk_q & (out_parity != in_expect).
  - out_count = final cnt; out_ovf = ovf_q; out_valid = 1.
  - Latency: result visible the cycle after the last word is accepted.
- HOLD:
  - out_valid stays high; all out_* stay stable until out_valid & out_ready.
  - On that edge: out_valid → 0, acc/cnt/ovf_q clear, → IDLE.
  - Next word is accepted no earlier than the following cycle (no same-cycle overlap).
- in_valid low in ACCUM: state and acc hold indefinitely (no timeout).
- Single-word frame (in_last on first word) is legal: IDLE → HOLD directly, count = 1.
- out_err is 0 whenever chk_q = 0.
- Reset (any state, including mid-frame or in HOLD):
  - Next edge forces IDLE and clears acc, cnt, ovf_q, chk_q.
  - odd_q ← ODD_DEFAULT.
  - out_valid/out_parity/out_err/out_ovf ← 0, out_count ← 0.
  - in_ready = 1 the cycle after rst deasserts; a partial frame is discarded.
- Parity width rule: ^in_data spans all DATA_W bits; the accumulator is 1 bit.

Test Plan:
- DATA_W=3, even, generate: eight single-word frames 3'b000..3'b111, out_ready=1 → out_parity = 0,1,1,0,1,0,0,1; out_count=1; out_valid one cycle after each accept.
- DATA_W=8, odd: frame 8'h01, 8'h03, 8'hFF(last) → XOR of popcounts 1+2+8 = 11 → 1, inverted → out_parity=0, out_count=3, out_err=0.
- Check mode: frame 8'hA5 with in_expect=1 → out_parity=0, out_err=1; repeat with in_expect=0 → out_err=0.
- Backpressure: after a result, hold out_ready=0 for 5 cycles while in_valid=1 with data 8'hFF → in_ready=0, out_* unchanged, no word absorbed; out_ready=1 → out_valid=0 next cycle, IDLE.
- Reset mid-frame: accept 8'h07, 8'h01, assert rst 1 cycle → outputs cleared; then frame 8'h01(last), even → out_parity=1, out_count=1.
- CNT_W=2: 5-word frame of 8'h00 → out_count=3, out_ovf=1, out_parity=0; next frame 8'h00(last) → out_ovf=0, out_count=1.
